isz_sequencer: RTL and testbench

Read-modify-write sequencer feeding the 12-bit incrementer for the ISZ instruction and, optionally, auto-index locations. It fetches an operand from memory and presents it to the incrementer with INC and OE asserted. It captures the incremented word and carry, writes the word back, and reports the skip condition to the instruction-execute control.

---
 rtl/isz_sequencer_if.sv | 36 +++
 rtl/isz_sequencer.sv | 154 +++++++++++++++
 tb/tb_isz_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/isz_sequencer_if.sv
// Bus bundle for the ISZ read-modify-write sequencer: request/status,
// memory port and incrementer port.
// master = sequencer side, slave = environment (control, memory, incrementer).
interface isz_sequencer_if;
  logic        START;
  logic        MODE;
  logic [11:0] ADDR;
  logic        BUSY;
  logic        DONE;
  logic        SKIP;
  logic        ERR;
  logic [11:0] RESULT;
  logic [11:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [11:0] MEM_WDATA;
  logic [11:0] MEM_RDATA;
  logic        MEM_ACK;
  logic [11:0] INC_IN;
  logic        INC_EN;
  logic        INC_OE;
  logic [11:0] INC_OUT;
  logic        INC_C;

  modport master (
    input  START, MODE, ADDR, MEM_RDATA, MEM_ACK, INC_OUT, INC_C,
    output BUSY, DONE, SKIP, ERR, RESULT, MEM_ADDR, MEM_RD, MEM_WR,
           MEM_WDATA, INC_IN, INC_EN, INC_OE
  );

  modport slave (
    output START, MODE, ADDR, MEM_RDATA, MEM_ACK, INC_OUT, INC_C,
    input  BUSY, DONE, SKIP, ERR, RESULT, MEM_ADDR, MEM_RD, MEM_WR,
           MEM_WDATA, INC_IN, INC_EN, INC_OE
  );
endinterface

// File: rtl/isz_sequencer.sv
// ISZ read-modify-write sequencer: fetch operand, run it through the external
// 12-bit incrementer, write the result back and report skip-on-zero.
// Optional feature macro: ISZ_AUTOINDEX_EN (auto-index locations 0010-0017).
// TIMEOUT > 0 bounds each memory access; 0 waits forever for MEM_ACK.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for START
// S_READ   | MEM_RD high until MEM_ACK, operand captured
// S_INCR   | one cycle driving the incrementer, result captured
// S_WRITE  | MEM_WR high with RESULT until MEM_ACK
// S_FINISH | DONE pulse, SKIP valid
module isz_sequencer #(
  parameter int TIMEOUT = 0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  isz_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_INCR, S_WRITE, S_FINISH
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t         state_q, state_d;
  logic [11:0]    addr_q, addr_d;
  logic [11:0]    oper_q, oper_d;
  logic [11:0]    result_q, result_d;
  logic           carry_q, carry_d;
  logic           skip_q, skip_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ai_win;     // auto-index location: increment, never skip
  logic           ai_bypass;  // auto-index request outside window: read only

`ifdef ISZ_AUTOINDEX_EN
  logic mode_q, mode_d;

  // Request mode, captured with the accepted START
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) mode_q <= 1'b0;
    else          mode_q <= mode_d;
  end

  assign mode_d    = (state_q == S_IDLE && bus.START) ? bus.MODE : mode_q;
  assign ai_win    = mode_q && (addr_q[11:3] == 9'd1);
  assign ai_bypass = mode_q && (addr_q[11:3] != 9'd1);
`else
  logic unused_mode;
  assign unused_mode = bus.MODE;
  assign ai_win      = 1'b0;
  assign ai_bypass   = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      oper_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      skip_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      oper_q   <= oper_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      skip_q   <= skip_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and register updates; the timeout counter counts down to zero
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    oper_d   = oper_q;
    result_d = result_q;
    carry_d  = carry_q;
    skip_d   = skip_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          addr_d   = bus.ADDR;
          result_d = '0;
          skip_d   = 1'b0;
          carry_d  = 1'b0;
          cnt_d    = TO_LOAD;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (bus.MEM_ACK) begin
          oper_d = bus.MEM_RDATA;
          cnt_d  = TO_LOAD;
          if (ai_bypass) begin
            result_d = bus.MEM_RDATA;
            state_d  = S_FINISH;
          end else begin
            state_d  = S_INCR;
          end
        end else if ((TIMEOUT > 0) && (cnt_q == '0)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_INCR: begin
        result_d = bus.INC_OUT;
        carry_d  = bus.INC_C;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (bus.MEM_ACK) begin
          // carry alone is not trusted: a skip also requires a zero result
          skip_d  = carry_q && (result_q == 12'd0) && !ai_win;
          state_d = S_FINISH;
        end else if ((TIMEOUT > 0) && (cnt_q == '0)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.DONE      = (state_q == S_FINISH);
  assign bus.SKIP      = skip_q;
  assign bus.ERR       = err_q;
  assign bus.RESULT    = result_q;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_RD    = (state_q == S_READ);
  assign bus.MEM_WR    = (state_q == S_WRITE);
  assign bus.MEM_WDATA = (state_q == S_WRITE) ? result_q : 12'd0;
  assign bus.INC_IN    = (state_q == S_INCR) ? oper_q : 12'd0;
  assign bus.INC_EN    = (state_q == S_INCR);
  assign bus.INC_OE    = (state_q == S_INCR);

endmodule

// File: tb/tb_isz_sequencer.sv
// Directed bench for isz_sequencer (TIMEOUT=4). The memory and incrementer
// are emulated cycle by cycle inside run_op; expectations are hand-computed.
module tb_isz_sequencer;
  logic CLK = 1'b0;
  logic RESET_N;

  isz_sequencer_if bus ();

  isz_sequencer #(.TIMEOUT(4)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.master)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int          done_cyc, err_cyc, done_cnt, err_cnt, rd_cyc, wr_cyc, inc_cyc, wr_acks;
  logic [11:0] inc_in_obs, wdata_obs, result_obs;
  logic        skip_obs;
  bit          overlap, addr_bad, busy_bad, inc_bad;

  // Issue one request and emulate memory/incrementer until DONE or ERR (bounded)
  task automatic run_op(input logic [11:0] a, input logic m, input logic [11:0] rd,
                        input int rw, input int ww, input bit never, input bit stray,
                        input bit poke);
    int rc = 0;
    int wc = 0;
    done_cyc = -1; err_cyc = -1; done_cnt = 0; err_cnt = 0;
    rd_cyc = 0; wr_cyc = 0; inc_cyc = -1; wr_acks = 0;
    inc_in_obs = '0; wdata_obs = '0; result_obs = '0; skip_obs = 1'b0;
    overlap = 0; addr_bad = 0; busy_bad = 0; inc_bad = 0;
    bus.ADDR = a; bus.MODE = m; bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (poke) begin
        bus.START = (cyc == 2);
        if (cyc == 2) bus.ADDR = 12'o7000;
      end
      if (bus.MEM_RD && bus.MEM_WR) overlap = 1;
      if (bus.BUSY && bus.MEM_ADDR !== a) addr_bad = 1;
      if (!bus.ERR && bus.BUSY !== 1'b1) busy_bad = 1;
      if (bus.INC_EN) begin
        inc_cyc = cyc; inc_in_obs = bus.INC_IN;
        if (!bus.INC_OE) inc_bad = 1;
      end else if (bus.INC_OE || bus.INC_IN !== 12'd0) begin
        inc_bad = 1;
      end
      bus.INC_OUT = bus.INC_OE ? bus.INC_IN + 12'd1 : 12'd0;
      bus.INC_C   = bus.INC_OE && (bus.INC_IN == 12'o7777);
      bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 12'd0;
      if (bus.MEM_RD) begin
        rd_cyc++;
        if (!never && rc == rw) begin bus.MEM_ACK = 1'b1; bus.MEM_RDATA = rd; end
        rc++;
      end else if (bus.MEM_WR) begin
        wr_cyc++;
        if (!never && wc == ww) begin
          bus.MEM_ACK = 1'b1; wdata_obs = bus.MEM_WDATA; wr_acks++;
        end
        wc++;
      end else if (stray) begin
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 12'o5555;
      end
      if (bus.DONE) begin
        done_cyc = cyc; done_cnt++; result_obs = bus.RESULT; skip_obs = bus.SKIP;
      end
      if (bus.ERR) begin err_cyc = cyc; err_cnt++; skip_obs = bus.SKIP; end
      if (bus.DONE || bus.ERR) break;
      @(posedge CLK); #1;
    end
    bus.MEM_ACK = 1'b0; bus.START = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.BUSY); end
    total++; if (bus.DONE !== 1'b0 || bus.ERR !== 1'b0 || bus.SKIP !== 1'b0) begin
      bad++; $display("FAIL reset_flags got done=%b err=%b skip=%b want 0", bus.DONE, bus.ERR, bus.SKIP); end
    total++; if (bus.RESULT !== 12'd0 || bus.MEM_ADDR !== 12'd0) begin
      bad++; $display("FAIL reset_regs got result=%o addr=%o want 0", bus.RESULT, bus.MEM_ADDR); end
    total++; if (bus.MEM_RD !== 1'b0 || bus.MEM_WR !== 1'b0 || bus.INC_EN !== 1'b0 || bus.INC_OE !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got rd=%b wr=%b en=%b oe=%b want 0", bus.MEM_RD, bus.MEM_WR, bus.INC_EN, bus.INC_OE); end
  endtask

  task automatic test_isz_basic();
    run_op(12'o0100, 1'b0, 12'o0017, 0, 0, 0, 0, 0);
    total++; if (inc_cyc != 2 || inc_in_obs !== 12'o0017) begin
      bad++; $display("FAIL basic_inc got cyc=%0d in=%o want cyc=2 in=0017", inc_cyc, inc_in_obs); end
    total++; if (wdata_obs !== 12'o0020 || wr_acks != 1) begin
      bad++; $display("FAIL basic_wdata got %o acks=%0d want 0020 acks=1", wdata_obs, wr_acks); end
    total++; if (done_cyc != 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", done_cyc); end
    total++; if (result_obs !== 12'o0020 || skip_obs !== 1'b0) begin
      bad++; $display("FAIL basic_result got=%o skip=%b want 0020 skip=0", result_obs, skip_obs); end
    total++; if (busy_bad || inc_bad || overlap) begin
      bad++; $display("FAIL basic_strobes got busy_bad=%0d inc_bad=%0d overlap=%0d want 0", busy_bad, inc_bad, overlap); end
  endtask

  task automatic test_isz_wrap();
    run_op(12'o0200, 1'b0, 12'o7777, 0, 0, 0, 1, 0);
    total++; if (wdata_obs !== 12'o0000) begin bad++; $display("FAIL wrap_wdata got=%o want=0000", wdata_obs); end
    total++; if (result_obs !== 12'o0000 || skip_obs !== 1'b1) begin
      bad++; $display("FAIL wrap_skip got result=%o skip=%b want 0000 skip=1", result_obs, skip_obs); end
    total++; if (done_cyc != 4) begin bad++; $display("FAIL wrap_stray_ack got done=%0d want=4", done_cyc); end
    @(posedge CLK); #1;
    total++; if (bus.SKIP !== 1'b1 || bus.RESULT !== 12'o0000 || bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL wrap_hold got skip=%b result=%o busy=%b want 1 0000 0", bus.SKIP, bus.RESULT, bus.BUSY); end
  endtask

  task automatic test_wait_states();
    run_op(12'o0300, 1'b0, 12'o0377, 3, 2, 0, 0, 1);
    total++; if (done_cyc != 9) begin bad++; $display("FAIL wait_latency got=%0d want=9", done_cyc); end
    total++; if (rd_cyc != 4 || wr_cyc != 3) begin
      bad++; $display("FAIL wait_strobe_len got rd=%0d wr=%0d want rd=4 wr=3", rd_cyc, wr_cyc); end
    total++; if (addr_bad || overlap || busy_bad) begin
      bad++; $display("FAIL wait_bus got addr_bad=%0d overlap=%0d busy_bad=%0d want 0", addr_bad, overlap, busy_bad); end
    total++; if (result_obs !== 12'o0400 || wdata_obs !== 12'o0400 || skip_obs !== 1'b0) begin
      bad++; $display("FAIL wait_result got result=%o wdata=%o skip=%b want 0400 0400 0", result_obs, wdata_obs, skip_obs); end
    @(posedge CLK); #1;
    total++; if (bus.BUSY !== 1'b0 || bus.MEM_RD !== 1'b0) begin
      bad++; $display("FAIL wait_no_queue got busy=%b rd=%b want 0 0", bus.BUSY, bus.MEM_RD); end
  endtask

  task automatic test_back_to_back();
    run_op(12'o0400, 1'b0, 12'o0001, 0, 0, 0, 0, 0);
    bus.START = 1'b1; bus.ADDR = 12'o0500; bus.MODE = 1'b0;
    @(posedge CLK); #1;
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL b2b_start_in_done got busy=%b want=0", bus.BUSY); end
    run_op(12'o0500, 1'b0, 12'o0041, 0, 0, 0, 0, 0);
    total++; if (done_cyc != 4 || result_obs !== 12'o0042) begin
      bad++; $display("FAIL b2b_second got done=%0d result=%o want 4 0042", done_cyc, result_obs); end
  endtask

  task automatic test_timeout();
    run_op(12'o0600, 1'b0, 12'o0000, 0, 0, 1, 0, 0);
    total++; if (rd_cyc != 4 || err_cyc != 5) begin
      bad++; $display("FAIL timeout_len got rd=%0d err_cyc=%0d want rd=4 err=5", rd_cyc, err_cyc); end
    total++; if (done_cnt != 0 || bus.BUSY !== 1'b0 || skip_obs !== 1'b0) begin
      bad++; $display("FAIL timeout_state got done=%0d busy=%b skip=%b want 0 0 0", done_cnt, bus.BUSY, skip_obs); end
    @(posedge CLK); #1;
    total++; if (bus.ERR !== 1'b0 || bus.MEM_RD !== 1'b0 || bus.DONE !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse got err=%b rd=%b done=%b want 0 0 0", bus.ERR, bus.MEM_RD, bus.DONE); end
  endtask

  task automatic test_reset_mid();
    bus.ADDR = 12'o0700; bus.MODE = 1'b0; bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 12'o0100;   // cycle 1: READ
    @(posedge CLK); #1;
    bus.MEM_ACK = 1'b0;
    bus.INC_OUT = bus.INC_IN + 12'd1; bus.INC_C = 1'b0;                // cycle 2: INCR
    @(posedge CLK); #1;
    bus.INC_OUT = 12'd0;                                               // cycle 3: WRITE
    total++; if (bus.MEM_WR !== 1'b1 || bus.RESULT !== 12'o0101) begin
      bad++; $display("FAIL midrst_pre got wr=%b result=%o want 1 0101", bus.MEM_WR, bus.RESULT); end
    #2 RESET_N = 1'b0;
    #1;
    total++; if (bus.MEM_WR !== 1'b0 || bus.BUSY !== 1'b0 || bus.RESULT !== 12'd0 || bus.DONE !== 1'b0) begin
      bad++; $display("FAIL midrst_async got wr=%b busy=%b result=%o done=%b want 0", bus.MEM_WR, bus.BUSY, bus.RESULT, bus.DONE); end
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;
    run_op(12'o0710, 1'b0, 12'o3333, 1, 0, 0, 0, 0);
    total++; if (done_cyc != 5 || result_obs !== 12'o3334 || wdata_obs !== 12'o3334) begin
      bad++; $display("FAIL midrst_after got done=%0d result=%o wdata=%o want 5 3334 3334", done_cyc, result_obs, wdata_obs); end
  endtask

`ifdef ISZ_AUTOINDEX_EN
  task automatic test_autoindex();
    run_op(12'o0012, 1'b1, 12'o7777, 0, 0, 0, 0, 0);
    total++; if (wdata_obs !== 12'o0000 || skip_obs !== 1'b0 || done_cnt != 1) begin
      bad++; $display("FAIL ai_window got wdata=%o skip=%b done=%0d want 0000 0 1", wdata_obs, skip_obs, done_cnt); end
    run_op(12'o0020, 1'b1, 12'o1234, 0, 0, 0, 0, 0);
    total++; if (wr_cyc != 0 || result_obs !== 12'o1234 || skip_obs !== 1'b0 || done_cnt != 1) begin
      bad++; $display("FAIL ai_bypass got wr=%0d result=%o skip=%b done=%0d want 0 1234 0 1", wr_cyc, result_obs, skip_obs, done_cnt); end
  endtask
`endif

  initial begin
    RESET_N = 1'b0;
    bus.START = 1'b0; bus.MODE = 1'b0; bus.ADDR = '0;
    bus.MEM_RDATA = '0; bus.MEM_ACK = 1'b0; bus.INC_OUT = '0; bus.INC_C = 1'b0;
    repeat (2) @(negedge CLK);
    test_reset();
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    test_isz_basic();
    @(posedge CLK); #1;
    test_isz_wrap();
    test_wait_states();
    test_back_to_back();
    @(posedge CLK); #1;
    test_timeout();
    test_reset_mid();
`ifdef ISZ_AUTOINDEX_EN
    @(posedge CLK); #1;
    test_autoindex();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
